// File: rtl/ecc_serial_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_serial_feeder_pkg
// Purpose  : Shared definitions for the ECC serial feeder and the wrapper it
//            drives: width-select encodings, register sizes, FSM states and
//            the mode-to-width helper.
// Revision : 1.0  initial release
// ============================================================================
package ecc_serial_feeder_pkg;

   // Widest operand carried by the serial protocol
   localparam int MAX_BITS = 256;
   // Width of the shared down-counter: it must hold MAX_BITS-1 and the gap
   localparam int MAX_REG  = $clog2(MAX_BITS) + 1;

   // Operand width select carried in the 2-bit mode field
   localparam logic [1:0] BITS32  = 2'b00;
   localparam logic [1:0] BITS64  = 2'b01;
   localparam logic [1:0] BITS128 = 2'b10;
   localparam logic [1:0] BITS256 = 2'b11;

   // Feeder sequence, one state per protocol window
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      MODE    = 3'd2,
      OPER    = 3'd3,
      GAP     = 3'd4,
      NPSTART = 3'd5,
      NP      = 3'd6,
      DONE    = 3'd7
   } feeder_state_t;

   // Returns W-1 for the selected operand width: the tap position and the
   // counter load value for the operand and nP windows
   function automatic logic [MAX_REG-1:0] mode_to_wm1(input logic [1:0] mode);
      logic [MAX_REG-1:0] wm1;
      case (mode)
         BITS32:  wm1 = MAX_REG'(31);
         BITS64:  wm1 = MAX_REG'(63);
         BITS128: wm1 = MAX_REG'(127);
         default: wm1 = MAX_REG'(255);
      endcase
      return wm1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_piso_shift.sv
`default_nettype none
// ============================================================================
// Module   : ecc_piso_shift
// Purpose  : Parallel-load, left-shift register. The serial bit is tapped at
//            position W-1, so narrow operands need no pre-alignment.
// Revision : 1.0  initial release
// ============================================================================
module ecc_piso_shift #(
   parameter int MAX_BITS = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load,
   input  logic [MAX_BITS-1:0]         load_data,
   input  logic                        shift,
   input  logic [$clog2(MAX_BITS)-1:0] tap_sel,
   output logic                        tap
);

   logic [MAX_BITS-1:0] r_sh;

   // Load a fresh operand on job acceptance, otherwise shift toward the MSB
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sh <= '0;
      end else if (load) begin
         r_sh <= load_data;
      end else if (shift) begin
         r_sh <= {r_sh[MAX_BITS-2:0], 1'b0};
      end
   end

   assign tap = r_sh[tap_sel];

endmodule
`default_nettype wire

// File: rtl/ecc_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module   : ecc_serial_feeder
// Purpose  : Accepts one parallel ECC job per handshake and replays it MSB
//            first onto the wrapper's bit-serial protocol: start pulse, mode,
//            operands, programmable gap, nP start pulse, nP, done pulse.
// Revision : 1.0  initial release
// ============================================================================
module ecc_serial_feeder #(
   parameter int MAX_BITS = 256,
   parameter int GAP_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                job_valid,
   output logic                job_ready,
   input  logic [1:0]          job_mode,
   input  logic [MAX_BITS-1:0] job_a,
   input  logic [MAX_BITS-1:0] job_b,
   input  logic [MAX_BITS-1:0] job_prime,
   input  logic [MAX_BITS-1:0] job_Px,
   input  logic [MAX_BITS-1:0] job_Py,
   input  logic [MAX_BITS-1:0] job_m,
   input  logic [MAX_BITS-1:0] job_nPx,
   input  logic [MAX_BITS-1:0] job_nPy,
   input  logic [GAP_W-1:0]    job_gap,
   output logic                ser_m_P_valid,
   output logic                ser_mode,
   output logic                ser_a,
   output logic                ser_b,
   output logic                ser_prime,
   output logic                ser_Px,
   output logic                ser_Py,
   output logic                ser_m,
   output logic                ser_nP_valid,
   output logic                ser_nPx,
   output logic                ser_nPy,
   output logic                job_done
);

   import ecc_serial_feeder_pkg::*;

   localparam int c_SEL_W   = $clog2(MAX_BITS);
   localparam int c_NUM_OPS = 8;
   localparam int c_NUM_CUR = 6;

   feeder_state_t r_state;
   feeder_state_t w_state_nxt;
   logic [MAX_REG-1:0] r_cnt;
   logic [MAX_REG-1:0] w_cnt_nxt;

   logic [1:0]         r_mode;
   logic [GAP_W-1:0]   r_gap;
   logic [MAX_REG-1:0] r_wm1;
   logic [MAX_REG-1:0] w_gap_m1;
   logic               w_accept;

   // Operand order: a, b, prime, Px, Py, m (operand window), nPx, nPy (nP window)
   logic [c_NUM_OPS-1:0][MAX_BITS-1:0] w_load_data;
   logic [c_NUM_OPS-1:0]               w_tap;
   logic [c_NUM_OPS-1:0]               w_shift;
   logic [c_SEL_W-1:0]                 w_tap_sel;

   logic                 w_m_P_valid_nxt;
   logic                 w_mode_nxt;
   logic [c_NUM_CUR-1:0] w_cur_nxt;
   logic                 w_nP_valid_nxt;
   logic [1:0]           w_np_nxt;
   logic                 w_ready_nxt;
   logic                 w_done_nxt;

   assign w_accept = job_valid && job_ready;

   // A zero gap is stretched to one idle cycle; the gap must fit the counter
   assign w_gap_m1 = (r_gap == '0) ? '0 : MAX_REG'(r_gap - GAP_W'(1));

   assign w_load_data = {job_nPy, job_nPx, job_m, job_Py, job_Px,
                         job_prime, job_b, job_a};
   assign w_tap_sel   = r_wm1[c_SEL_W-1:0];

   // Shift on the edge that opens each data cycle, so the tap already shows
   // the next bit when the output register samples it
   assign w_shift = {{2{w_state_nxt == NP}}, {c_NUM_CUR{w_state_nxt == OPER}}};

   for (genvar gi = 0; gi < c_NUM_OPS; gi++) begin : g_piso
      ecc_piso_shift #(
         .MAX_BITS (MAX_BITS)
      ) u_piso (
         .clk       (clk),
         .rst       (rst),
         .load      (w_accept),
         .load_data (w_load_data[gi]),
         .shift     (w_shift[gi]),
         .tap_sel   (w_tap_sel),
         .tap       (w_tap[gi])
      );
   end

   // Capture the job's control fields on acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode <= '0;
         r_gap  <= '0;
         r_wm1  <= '0;
      end else if (w_accept) begin
         r_mode <= job_mode;
         r_gap  <= job_gap;
         r_wm1  <= mode_to_wm1(job_mode);
      end
   end

   // State and shared down-counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state, counter load/decrement and next output values
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = START;
         end
         START: begin
            w_state_nxt = MODE;
            w_cnt_nxt   = MAX_REG'(1);
         end
         MODE: begin
            if (r_cnt == '0) begin
               w_state_nxt = OPER;
               w_cnt_nxt   = r_wm1;
            end else begin
               w_cnt_nxt = r_cnt - MAX_REG'(1);
            end
         end
         OPER: begin
            if (r_cnt == '0) begin
               w_state_nxt = GAP;
               w_cnt_nxt   = w_gap_m1;
            end else begin
               w_cnt_nxt = r_cnt - MAX_REG'(1);
            end
         end
         GAP: begin
            if (r_cnt == '0) begin
               w_state_nxt = NPSTART;
            end else begin
               w_cnt_nxt = r_cnt - MAX_REG'(1);
            end
         end
         NPSTART: begin
            w_state_nxt = NP;
            w_cnt_nxt   = r_wm1;
         end
         NP: begin
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - MAX_REG'(1);
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Outputs are decoded from the upcoming state and registered below.
      // In MODE the counter runs 1 then 0, selecting mode[1] then mode[0].
      w_m_P_valid_nxt = (w_state_nxt == START);
      w_mode_nxt      = (w_state_nxt == MODE) ? r_mode[w_cnt_nxt[0]] : 1'b0;
      w_cur_nxt       = (w_state_nxt == OPER) ? w_tap[c_NUM_CUR-1:0] : '0;
      w_nP_valid_nxt  = (w_state_nxt == NPSTART);
      w_np_nxt        = (w_state_nxt == NP) ? w_tap[c_NUM_OPS-1:c_NUM_CUR] : '0;
      w_ready_nxt     = (w_state_nxt == IDLE);
      w_done_nxt      = (w_state_nxt == DONE);
   end

   // Registered protocol outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         job_ready     <= 1'b1;
         job_done      <= 1'b0;
         ser_m_P_valid <= 1'b0;
         ser_mode      <= 1'b0;
         ser_a         <= 1'b0;
         ser_b         <= 1'b0;
         ser_prime     <= 1'b0;
         ser_Px        <= 1'b0;
         ser_Py        <= 1'b0;
         ser_m         <= 1'b0;
         ser_nP_valid  <= 1'b0;
         ser_nPx       <= 1'b0;
         ser_nPy       <= 1'b0;
      end else begin
         job_ready     <= w_ready_nxt;
         job_done      <= w_done_nxt;
         ser_m_P_valid <= w_m_P_valid_nxt;
         ser_mode      <= w_mode_nxt;
         ser_a         <= w_cur_nxt[0];
         ser_b         <= w_cur_nxt[1];
         ser_prime     <= w_cur_nxt[2];
         ser_Px        <= w_cur_nxt[3];
         ser_Py        <= w_cur_nxt[4];
         ser_m         <= w_cur_nxt[5];
         ser_nP_valid  <= w_nP_valid_nxt;
         ser_nPx       <= w_np_nxt[0];
         ser_nPy       <= w_np_nxt[1];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ecc_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_serial_feeder
// Purpose  : Self-checking bench for ecc_serial_feeder with a wrapper-side
//            receiver model and an expected-job scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_ecc_serial_feeder;

   localparam int MB = 256;

   typedef struct packed {
      logic [1:0]          mode;
      logic [7:0][MB-1:0]  op;
      logic [7:0]          gap;
   } job_t;

   typedef struct packed {
      logic [1:0]          mode;
      logic [7:0][MB-1:0]  op;
      int                  t0;
      int                  tnp;
      int                  tdone;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          job_valid = 1'b0;
   logic          job_ready;
   logic [1:0]    job_mode = '0;
   logic [MB-1:0] job_a = '0, job_b = '0, job_prime = '0, job_Px = '0;
   logic [MB-1:0] job_Py = '0, job_m = '0, job_nPx = '0, job_nPy = '0;
   logic [7:0]    job_gap = '0;
   logic          ser_m_P_valid, ser_mode, ser_a, ser_b, ser_prime, ser_Px;
   logic          ser_Py, ser_m, ser_nP_valid, ser_nPx, ser_nPy, job_done;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   stray = 0;
   int   done_cnt = 0;
   int   n_exp_done = 0;
   int   last_t0 = 0;
   exp_t exp_q[$];

   ecc_serial_feeder #(
      .MAX_BITS (MB),
      .GAP_W    (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_mode      (job_mode),
      .job_a         (job_a),
      .job_b         (job_b),
      .job_prime     (job_prime),
      .job_Px        (job_Px),
      .job_Py        (job_Py),
      .job_m         (job_m),
      .job_nPx       (job_nPx),
      .job_nPy       (job_nPy),
      .job_gap       (job_gap),
      .ser_m_P_valid (ser_m_P_valid),
      .ser_mode      (ser_mode),
      .ser_a         (ser_a),
      .ser_b         (ser_b),
      .ser_prime     (ser_prime),
      .ser_Px        (ser_Px),
      .ser_Py        (ser_Py),
      .ser_m         (ser_m),
      .ser_nP_valid  (ser_nP_valid),
      .ser_nPx       (ser_nPx),
      .ser_nPy       (ser_nPy),
      .job_done      (job_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int width_of(input logic [1:0] m);
      case (m)
         2'b00:   return 32;
         2'b01:   return 64;
         2'b10:   return 128;
         default: return 256;
      endcase
   endfunction

   function automatic logic [MB-1:0] mask_of(input logic [1:0] m);
      logic [MB-1:0] ones;
      ones = '1;
      return ones >> (MB - width_of(m));
   endfunction

   function automatic logic [MB-1:0] rand256();
      logic [MB-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic job_t rand_job(input logic [1:0] m, input logic [7:0] g);
      job_t j;
      j.mode = m;
      j.gap  = g;
      for (int i = 0; i < 8; i++) j.op[i] = rand256();
      return j;
   endfunction

   // Offer a job from a negedge, wait for the handshake, push the expectation
   task automatic drive_job(input job_t j, input bit keep_valid);
      int   n;
      int   w;
      int   g;
      exp_t e;
      job_mode  = j.mode;
      job_a     = j.op[0];
      job_b     = j.op[1];
      job_prime = j.op[2];
      job_Px    = j.op[3];
      job_Py    = j.op[4];
      job_m     = j.op[5];
      job_nPx   = j.op[6];
      job_nPy   = j.op[7];
      job_gap   = j.gap;
      job_valid = 1'b1;
      n = 0;
      while (job_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (job_ready !== 1'b1) begin
         chk("ready_timeout", 0, 1);
         job_valid = 1'b0;
         return;
      end
      w = width_of(j.mode);
      g = (j.gap == 8'd0) ? 1 : int'(j.gap);
      e.mode = j.mode;
      for (int i = 0; i < 8; i++) e.op[i] = j.op[i] & mask_of(j.mode);
      e.t0    = cyc + 1;
      e.tnp   = e.t0 + w + 3 + g;
      e.tdone = e.t0 + 2 * w + 4 + g;
      exp_q.push_back(e);
      last_t0 = e.t0;
      n_exp_done++;
      @(posedge clk);
      #1;
      // Inputs are don't-care after acceptance; scramble them
      job_valid = keep_valid;
      job_mode  = 2'($urandom);
      job_gap   = 8'($urandom);
      job_a     = rand256();
      job_b     = rand256();
      job_prime = rand256();
      job_Px    = rand256();
      job_Py    = rand256();
      job_m     = rand256();
      job_nPx   = rand256();
      job_nPy   = rand256();
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", exp_q.size(), 0);
         n_exp_done -= exp_q.size();
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // Wrapper-side receiver model
   int                 mst = 0;
   int                 k = 0;
   int                 gw = 32;
   int                 m_t0 = 0;
   int                 m_tnp = 0;
   logic [1:0]         gmode;
   logic [7:0][MB-1:0] got;
   logic [11:0]        lines;
   logic [11:0]        allow;
   exp_t               pe;
   string              c_names[8] = '{"a", "b", "prime", "Px", "Py", "m", "nPx", "nPy"};

   always @(negedge clk) begin
      if (!rst) begin
         mst = 0;
      end else begin
         lines = {ser_m_P_valid, ser_mode, ser_a, ser_b, ser_prime, ser_Px,
                  ser_Py, ser_m, ser_nP_valid, ser_nPx, ser_nPy, job_done};
         case (mst)
            0:       allow = 12'h800;
            1:       allow = 12'h400;
            2:       allow = 12'h3F0;
            3:       allow = 12'h008;
            4:       allow = 12'h006;
            default: allow = 12'h001;
         endcase
         if ((lines & ~allow) != 12'h000) stray++;
         if (job_ready !== (mst == 0 && !ser_m_P_valid)) stray++;
         if (job_done) done_cnt++;
         case (mst)
            0: begin
               if (ser_m_P_valid) begin
                  m_t0  = cyc;
                  got   = '0;
                  gmode = '0;
                  k     = 0;
                  mst   = 1;
               end
            end
            1: begin
               gmode = {gmode[0], ser_mode};
               k++;
               if (k == 2) begin
                  gw  = width_of(gmode);
                  k   = 0;
                  mst = 2;
               end
            end
            2: begin
               for (int i = 0; i < 6; i++) got[i] = {got[i][MB-2:0], lines[9-i]};
               k++;
               if (k == gw) begin
                  k   = 0;
                  mst = 3;
               end
            end
            3: begin
               if (ser_nP_valid) begin
                  m_tnp = cyc;
                  k     = 0;
                  mst   = 4;
               end else begin
                  k++;
                  if (k > 400) begin
                     stray++;
                     mst = 0;
                  end
               end
            end
            4: begin
               got[6] = {got[6][MB-2:0], ser_nPx};
               got[7] = {got[7][MB-2:0], ser_nPy};
               k++;
               if (k == gw) mst = 5;
            end
            default: begin
               mst = 0;
               chk("done_pulse", job_done, 1);
               if (exp_q.size() == 0) begin
                  chk("unexpected_job", 1, 0);
               end else begin
                  pe = exp_q.pop_front();
                  chk("mode", gmode, pe.mode);
                  for (int i = 0; i < 8; i++) chk(c_names[i], got[i], pe.op[i]);
                  chk("t_start", m_t0, pe.t0);
                  chk("t_nP_valid", m_tnp, pe.tnp);
                  chk("t_done", cyc, pe.tdone);
               end
            end
         endcase
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      job_t j;
      int   t1;

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ready", job_ready, 1);
      chk("reset_done", job_done, 0);
      chk("reset_lines", {ser_m_P_valid, ser_mode, ser_a, ser_b, ser_prime, ser_Px,
                          ser_Py, ser_m, ser_nP_valid, ser_nPx, ser_nPy}, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 32-bit job, Px MSB and LSB only, gap 3
      j = '0;
      j.mode  = 2'b00;
      j.gap   = 8'd3;
      j.op[3] = 256'h8000_0001;
      drive_job(j, 1'b0);
      wait_idle();

      // 256-bit job, m all ones, zero gap stretched to one
      j = '0;
      j.mode  = 2'b11;
      j.gap   = 8'd0;
      j.op[5] = '1;
      drive_job(j, 1'b0);
      wait_idle();

      // 64-bit job: bits above 63 must not be transmitted
      j = rand_job(2'b01, 8'd2);
      j.op[4][100] = 1'b1;
      j.op[4][63]  = 1'b0;
      drive_job(j, 1'b0);
      wait_idle();

      // Random operands in every mode
      for (int md = 0; md < 4; md++) begin
         j = rand_job(2'(md), 8'($urandom_range(0, 5)));
         drive_job(j, 1'b0);
         wait_idle();
      end

      // Back-to-back with job_valid held high: identical jobs
      j = rand_job(2'b00, 8'd2);
      drive_job(j, 1'b1);
      t1 = last_t0;
      drive_job(j, 1'b0);
      chk("b2b_accept_cycle", last_t0, t1 + 2 * 32 + 6 + 2);
      wait_idle();

      // Reset at cycle 10 of a 128-bit job
      j = rand_job(2'b10, 8'd1);
      drive_job(j, 1'b0);
      while (cyc < last_t0 + 10) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_ready", job_ready, 1);
      chk("abort_lines", {ser_m_P_valid, ser_mode, ser_a, ser_b, ser_prime, ser_Px,
                          ser_Py, ser_m, ser_nP_valid, ser_nPx, ser_nPy, job_done}, 0);
      exp_q.delete();
      n_exp_done--;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Fresh job after the abort
      j = rand_job(2'b10, 8'd4);
      drive_job(j, 1'b0);
      wait_idle();

      chk("stray_activity", stray, 0);
      chk("done_count", done_cnt, n_exp_done);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
